// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, runs the request/valid handshake to
// instruction memory and holds the fetched word steady for one execute window.
module ifetch_unit #(
    parameter logic [31:0] PC_RESET        = 32'h0000_0000,
    parameter int          IMEM_ADDR_WIDTH = 14
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       Branch,
    input  logic                       nBranch,
    input  logic                       Jmp,
    input  logic                       Jal,
    input  logic                       Jr,
    input  logic                       Zero,
    input  logic [31:0]                Addr_result,
    input  logic [31:0]                Read_data_1,
    input  logic                       stall,
    output logic                       imem_req,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       imem_valid,
    output logic [31:0]                Instruction,
    output logic [5:0]                 Opcode,
    output logic [5:0]                 Function_opcode,
    output logic                       inst_valid,
    output logic [31:0]                pc,
    output logic [31:0]                link_addr,
    output logic [31:0]                inst_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_EXEC  = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] inst_count_q;
    logic        req_q;
    logic        inst_valid_q;

    logic [31:0] pc_plus4_s;
    logic        branch_taken_s;
    logic [31:0] target_s;
    logic [31:0] next_pc_d;

    assign pc_plus4_s     = pc_q + 32'd4;
    assign branch_taken_s = (Branch & Zero) | (nBranch & ~Zero);

    // Next-PC selection; register-jump beats absolute jump beats conditional branch.
    always_comb begin
        target_s = pc_plus4_s;
        if (Jr) begin
            target_s = Read_data_1;
        end else if (Jmp || Jal) begin
            target_s = {pc_plus4_s[31:28], instr_q[25:0], 2'b00};
        end else if (branch_taken_s) begin
            target_s = Addr_result;
        end else begin
            target_s = pc_plus4_s;
        end
        next_pc_d = target_s & ~32'd3;
    end

    // Fetch/execute sequencer with registered request and valid strobes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= PC_RESET;
            instr_q      <= 32'd0;
            inst_count_q <= 32'd0;
            req_q        <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_FETCH: begin
                    state_q <= S_WAIT;
                    req_q   <= 1'b0;
                end
                S_WAIT: begin
                    // No timeout: memory is trusted to answer eventually.
                    if (imem_valid) begin
                        instr_q      <= imem_rdata;
                        inst_valid_q <= 1'b1;
                        state_q      <= S_EXEC;
                    end else begin
                        state_q      <= S_WAIT;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        pc_q         <= next_pc_d;
                        inst_count_q <= inst_count_q + 32'd1;
                        inst_valid_q <= 1'b0;
                        req_q        <= 1'b1;
                        state_q      <= S_FETCH;
                    end else begin
                        state_q      <= S_EXEC;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_q        <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // pc only moves on EXEC exit, so the address is stable through WAIT.
    assign imem_addr       = pc_q[IMEM_ADDR_WIDTH+1:2];
    assign imem_req        = req_q;
    assign Instruction     = instr_q;
    assign Opcode          = instr_q[31:26];
    assign Function_opcode = instr_q[5:0];
    assign inst_valid      = inst_valid_q;
    assign pc              = pc_q;
    assign link_addr       = pc_plus4_s;
    assign inst_count      = inst_count_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomised bench for ifetch_unit against a transaction-level fetch model.
module tb_ifetch_unit;

    localparam int AW = 14;

    logic          clock, reset;
    logic          Branch, nBranch, Jmp, Jal, Jr, Zero, stall;
    logic [31:0]   Addr_result, Read_data_1;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          imem_valid;
    logic [31:0]   Instruction;
    logic [5:0]    Opcode, Function_opcode;
    logic          inst_valid;
    logic [31:0]   pc, link_addr, inst_count;

    ifetch_unit #(.PC_RESET(32'h0000_0000), .IMEM_ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr),
        .Zero(Zero), .Addr_result(Addr_result), .Read_data_1(Read_data_1),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .Instruction(Instruction), .Opcode(Opcode), .Function_opcode(Function_opcode),
        .inst_valid(inst_valid), .pc(pc), .link_addr(link_addr), .inst_count(inst_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          prev_req = 0;
    int          exp_period = -1;
    logic [31:0] m_pc;
    logic [31:0] m_count;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
    endtask

    // Architectural next-PC rule, written from the ISA's point of view.
    function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] word,
                                               input logic jr, input logic jmp, input logic jal,
                                               input logic br, input logic nbr, input logic z,
                                               input logic [31:0] ar, input logic [31:0] rd1);
        logic [31:0] seq;
        logic [31:0] tgt;
        seq = cur_pc + 32'd4;
        if (jr)                          tgt = rd1;
        else if (jmp || jal)             tgt = (seq & 32'hF000_0000) | ({6'd0, word[25:0]} << 2);
        else if ((br && z) || (nbr && !z)) tgt = ar;
        else                             tgt = seq;
        return tgt - (tgt % 32'd4);
    endfunction

    task automatic drive_ctl(input logic jr, input logic jmp, input logic jal, input logic br,
                             input logic nbr, input logic z, input logic [31:0] ar, input logic [31:0] rd1);
        Jr = jr; Jmp = jmp; Jal = jal; Branch = br; nBranch = nbr; Zero = z;
        Addr_result = ar; Read_data_1 = rd1;
    endtask

    task automatic wait_req();
        int waited;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            waited++;
            if (imem_req === 1'b1) break;
        end
        check_val("imem_req_seen", 32'(imem_req), 32'd1);
        check_val("req_delay", 32'(waited), 32'd1);
        check_val("fetch_inst_valid", 32'(inst_valid), 32'd0);
        check_val("imem_addr", 32'(imem_addr), 32'(m_pc[AW+1:2]));
    endtask

    task automatic run_instr(input logic [31:0] word, input int lat, input int stalls,
                             input logic jr, input logic jmp, input logic jal, input logic br,
                             input logic nbr, input logic z, input logic [31:0] ar, input logic [31:0] rd1);
        wait_req();
        if (exp_period > 0) check_val("period", 32'(cyc - prev_req), 32'(exp_period));
        prev_req = cyc;
        // valid seen in FETCH must be ignored
        imem_valid = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        for (int i = 1; i <= lat; i++) begin
            tick();
            check_val("wait_req_low", 32'(imem_req), 32'd0);
            check_val("wait_addr", 32'(imem_addr), 32'(m_pc[AW+1:2]));
            check_val("wait_inst_valid", 32'(inst_valid), 32'd0);
            imem_valid = (i == lat);
            imem_rdata = (i == lat) ? word : $urandom;
        end
        tick();
        imem_valid = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        for (int s = 0; s <= stalls; s++) begin
            check_val("inst_valid", 32'(inst_valid), 32'd1);
            check_val("instruction", Instruction, word);
            check_val("opcode", 32'(Opcode), 32'(word[31:26]));
            check_val("funct", 32'(Function_opcode), 32'(word[5:0]));
            check_val("pc", pc, m_pc);
            check_val("link_addr", link_addr, m_pc + 32'd4);
            check_val("inst_count", inst_count, m_count);
            check_val("exec_req_low", 32'(imem_req), 32'd0);
            if (s < stalls) begin
                stall = 1'b1;
                drive_ctl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom, $urandom);
                tick();
            end else begin
                stall = 1'b0;
                drive_ctl(jr, jmp, jal, br, nbr, z, ar, rd1);
            end
        end
        m_pc       = model_next(m_pc, word, jr, jmp, jal, br, nbr, z, ar, rd1);
        m_count    = m_count + 32'd1;
        exp_period = 2 + lat + stalls;
    endtask

    task automatic check_reset_state();
        check_val("rst_pc", pc, 32'h0000_0000);
        check_val("rst_instr", Instruction, 32'd0);
        check_val("rst_opcode", 32'(Opcode), 32'd0);
        check_val("rst_funct", 32'(Function_opcode), 32'd0);
        check_val("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_val("rst_imem_req", 32'(imem_req), 32'd0);
        check_val("rst_count", inst_count, 32'd0);
        check_val("rst_link", link_addr, 32'h0000_0004);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; imem_valid = 1'b0; imem_rdata = 32'd0;
        drive_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        m_pc = 32'd0; m_count = 32'd0;
        tick(); tick();
        check_reset_state();
        reset = 1'b0;

        // Three back-to-back sequential fetches with single-cycle memory
        for (int k = 0; k < 3; k++)
            run_instr($urandom, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        // jr to 0x10 (count should read 3 here)
        run_instr($urandom, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_0010);
        run_instr(32'h1000_0003, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 32'd0);
        run_instr($urandom, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_0010);
        run_instr(32'h1000_0003, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'd0);
        run_instr(32'h1400_0003, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
        run_instr($urandom, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h1000_0004);
        run_instr(32'h0C00_0020, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        run_instr($urandom, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_0123);
        run_instr($urandom, 3, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        run_instr($urandom, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset in WAIT, late response lands in IDLE and must be dropped
        wait_req();
        imem_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_reset_state();
        reset = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        m_pc = 32'd0; m_count = 32'hFFFF_FFFF; exp_period = -1;
        dut.inst_count_q = 32'hFFFF_FFFF;
        run_instr(32'h0123_4567, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        run_instr($urandom, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        for (int n = 0; n < 150; n++)
            run_instr($urandom, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
        run_instr($urandom, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage of the MIPS CPU, directly upstream of the main controller. Holds the program counter and drives a request/valid handshake to the instruction memory. Presents the fetched word, with its Opcode and Function_opcode fields split out, for one execute window. Computes the next PC from the controller's Branch/nBranch/Jmp/Jal/Jr decisions and the ALU's Zero/Addr_result.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000, byte address loaded into PC on reset
- IMEM_ADDR_WIDTH, 14, word-address width of instruction memory

Ports:
- clock  in  1  single system clock, rising-edge
- reset  in  1  asynchronous, active-high
- Branch / nBranch / Jmp / Jal / Jr  in  1 each  from controller, sampled only in EXEC
- Zero  in  1  ALU zero flag
- Addr_result  in  32  ALU-computed branch target (byte address)
- Read_data_1  in  32  rs value, jr target
- stall  in  1  hold current instruction in EXEC
- imem_req  out  1  one-cycle fetch request
- imem_addr  out  IMEM_ADDR_WIDTH  word address, pc[IMEM_ADDR_WIDTH+1:2]
- imem_rdata  in  32  instruction word
- imem_valid  in  1  imem_rdata valid this cycle
- Instruction  out  32  registered fetched word
- Opcode  out  6  Instruction[31:26]
- Function_opcode  out  6  Instruction[5:0]
- inst_valid  out  1  high throughout EXEC
- pc  out  32  address of current instruction
- link_addr  out  32  pc + 4, combinational; jal return address
- inst_count  out  32  retired-instruction counter

## Operation
- States: IDLE, FETCH, WAIT, EXEC.
- IDLE: entered only from reset; next cycle goes to FETCH.
- FETCH: imem_req=1 for exactly one cycle, imem_addr from pc; go to WAIT.
- WAIT: on imem_valid, latch imem_rdata into Instruction and go to EXEC. Otherwise stay in WAIT; no timeout.
- imem_valid outside WAIT is ignored.
- EXEC: inst_valid=1; controller and ALU resolve combinationally.
  - stall=1: remain in EXEC. pc, Instruction and inst_count unchanged.
  - stall=0: pc <= next_pc, inst_count += 1 (wraps 2^32-1 -> 0), go to FETCH.
- next_pc priority, highest first:
  1. Jr -> Read_data_1
  2. Jmp or Jal -> {pc_plus4[31:28], Instruction[25:0], 2'b00}
  3. (Branch && Zero) or (nBranch && !Zero) -> Addr_result
  4. else -> pc + 4
- pc_plus4 = pc + 4, modulo 2^32.
- next_pc[1:0] is always forced to 2'b00; no alignment exception.
- Branch and nBranch both high: the OR of both conditions selects Addr_result.
- imem_addr truncates pc above bit IMEM_ADDR_WIDTH+1, so the address wraps within instruction memory.

## Timing
- Reset values: state=IDLE, pc=PC_RESET, Instruction=0, inst_valid=0, imem_req=0, inst_count=0. Derived outputs: Opcode=0, Function_opcode=0, link_addr=PC_RESET+4.
- Reset asserted mid-operation (any state) aborts immediately. A response still in flight is discarded: it can only arrive in IDLE or FETCH, where imem_valid is ignored. Instruction memory shares this reset.
- Minimum instruction period is 3 cycles: FETCH, then WAIT with valid next cycle, then EXEC. Each extra memory wait cycle adds 1.
- imem_req high only in FETCH; imem_addr stable from FETCH until imem_valid.
- Instruction, Opcode and Function_opcode are stable for the whole EXEC window, including stalls.
- Control inputs are sampled on the EXEC-exit edge only.

## Test plan
- Reset release with PC_RESET=0 and memory valid 1 cycle after req: imem_req pulses at cycles 1, 4, 7 with imem_addr 0, 1, 2; inst_count reaches 3 after the third EXEC.
- beq at pc=0x10 with Zero=1, Addr_result=0x40 -> next pc=0x40. Same with Zero=0 -> pc=0x14. bne with Zero=0, Addr_result=0x40 -> pc=0x40.
- jal, Instruction=0x0C00_0020, at pc=0x1000_0004: link_addr=0x1000_0008 during EXEC; next pc=0x1000_0080.
- jr with Read_data_1=0x0000_0123 and Jmp also high -> pc=0x0000_0120 (Jr wins, low bits cleared).
- stall held 5 cycles in EXEC with 3-cycle memory latency: Instruction unchanged, no imem_req; then one increment of inst_count. The EXEC-to-EXEC period is 5 stall cycles plus 5 base cycles.
- Reset asserted in WAIT, with imem_valid arriving the cycle after reset deasserts (state IDLE): the response is ignored, pc=PC_RESET, and a fresh FETCH follows. Also preload inst_count=0xFFFF_FFFF and retire one instruction -> inst_count=0.
